data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the cpu's data-memory port and the 32-bit-block main memory. It answers the cpu's READ/WRITE/ADDRESS/WRITEDATA request with READDATA and BUSYWAIT. Hits complete with zero stall cycles. Misses stall the cpu while the cache writes back a dirty victim block and refills from main memory through a second busywait handshake.

## Interface
- No parameters. Geometry is fixed by package constants: 8 lines, 4-byte blocks, 3-bit tag, 3-bit index, 2-bit offset.
- CLK  in  1  single clock. State and arrays update on posedge.
- RESET  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- READ  in  1  cpu load request, held until BUSYWAIT low.
- WRITE  in  1  cpu store request, held until BUSYWAIT low.
- ADDRESS  in  8  byte address: tag [7:5], index [4:2], offset [1:0].
- WRITEDATA  in  8  store byte.
- READDATA  out  8  load byte.
- BUSYWAIT  out  1  cpu stall, combinational.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  victim block, byte 0 in [7:0].
- MEM_READDATA  in  32  refill block, byte 0 in [7:0].
- MEM_BUSYWAIT  in  1  memory busy. Memory raises it combinationally with a request and drops it in the cycle its transfer completes.

## Operation
- Per line: valid, dirty, 3-bit tag, 32-bit data.
- hit = valid[index] & (tag[index] == ADDRESS[7:5]).
- IDLE:
  - No request: nothing happens.
  - Hit: READDATA = selected byte, combinational. A hit WRITE stores WRITEDATA into the selected byte at posedge and sets dirty.
  - Miss with dirty victim: go to WRITEBACK.
  - Miss with clean victim: go to FETCH.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data.
  - At the posedge with MEM_BUSYWAIT=0, go to FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2].
  - At the posedge with MEM_BUSYWAIT=0, load MEM_READDATA and the new tag, set valid=1 and dirty=0, then go to IDLE.
  - The held request then hits and completes as a hit.
- BUSYWAIT = (READ|WRITE) & !(state==IDLE & hit).
- READDATA is 8'h00 unless READ & hit in IDLE.
- READ and WRITE both high: treated as WRITE.
- Request dropped mid-miss (protocol violation): the memory transfer still completes and the refill is installed, then the cache returns to IDLE.
- MEM_READ and MEM_WRITE are never high together. Memory outputs are 0 in IDLE.

## Timing
- RESET assertion, asynchronous:
  - state=IDLE; all valid and dirty bits=0.
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
  - BUSYWAIT=0 while RESET is high.
  - Data and tag arrays need no reset.
- Reset mid-miss: the memory request drops immediately and the in-flight transfer is abandoned.
- Hit: 0 stall cycles. A store is visible to a load in the next cycle.
- Memory contract: busy for L cycles, then low for one completing cycle.
  - Clean miss: BUSYWAIT high for L+2 cycles (1 IDLE detect + L+1 FETCH).
  - Dirty miss: BUSYWAIT high for 2L+3 cycles.
- A request arriving in the same cycle as RESET deassertion is evaluated normally in IDLE.

## Structure
- Package dcache_pkg holds:
  - state enum {IDLE, WRITEBACK, FETCH};
  - TAG_W=3, INDEX_W=3, OFFSET_W=2, NUM_LINES=8, BLOCK_W=32.
- Sub-module dcache_line_array holds:
  - the valid, dirty, tag and data arrays;
  - the byte-select read mux;
  - the byte-write and full-block refill write ports.
- data_cache holds the FSM, hit logic and memory-port drive.

## Test plan
- Reset, then READ 0x24 with memory block 6 = 0x44332211, L=4:
  - BUSYWAIT high for 6 cycles with MEM_ADDRESS=6'h09;
  - then READDATA=0x11.
- Hit, then READ 0x27 right after: BUSYWAIT stays 0 and READDATA=0x44 in the same cycle.
- WRITE 0x25 = 0xAB (hit), then READ 0x25: 0 stalls, READDATA=0xAB, line dirty.
- READ 0xA4 (same index 1, new tag), L=4:
  - MEM_WRITE with MEM_ADDRESS=6'h09 and MEM_WRITEDATA=0x4433AB11;
  - then MEM_READ with MEM_ADDRESS=6'h29;
  - BUSYWAIT high for 11 cycles.
- WRITE miss 0x03 = 0x5A on a clean line:
  - refill of block 0 (FETCH only, no MEM_WRITE);
  - then the byte is written and dirty=1.
- Assert RESET during FETCH:
  - MEM_READ drops within the same cycle;
  - a subsequent READ of the same address misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry and FSM state encoding for the direct-mapped data cache.
package dcache_pkg;
    localparam int TAG_W     = 3;
    localparam int INDEX_W   = 3;
    localparam int OFFSET_W  = 2;
    localparam int NUM_LINES = 8;
    localparam int BLOCK_W   = 32;
    localparam int BYTE_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } state_t;
endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage with a byte-select read port, a byte store port
// and a full-block refill port.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    input  logic                byte_we,
    input  logic [BYTE_W-1:0]   byte_wdata,
    input  logic                refill_we,
    input  logic [INDEX_W-1:0]  refill_index,
    input  logic [TAG_W-1:0]    refill_tag,
    input  logic [BLOCK_W-1:0]  refill_data,
    output logic                line_valid,
    output logic                line_dirty,
    output logic [TAG_W-1:0]    line_tag,
    output logic [BLOCK_W-1:0]  line_data,
    output logic [BYTE_W-1:0]   rd_byte
);
    logic [NUM_LINES-1:0] valid_vec;
    logic [NUM_LINES-1:0] dirty_vec;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_mem [NUM_LINES];

    // Only the status bits are reset; tags and data are qualified by valid.
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic valid_bit_reg;
            logic dirty_bit_reg;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    valid_bit_reg <= 1'b0;
                    dirty_bit_reg <= 1'b0;
                end else if (refill_we && refill_index == INDEX_W'(gi)) begin
                    valid_bit_reg <= 1'b1;
                    dirty_bit_reg <= 1'b0;
                end else if (byte_we && rd_index == INDEX_W'(gi)) begin
                    dirty_bit_reg <= 1'b1;
                end
            end

            assign valid_vec[gi] = valid_bit_reg;
            assign dirty_vec[gi] = dirty_bit_reg;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (refill_we) begin
            tag_mem[refill_index]  <= refill_tag;
            data_mem[refill_index] <= refill_data;
        end else if (byte_we) begin
            data_mem[rd_index][{rd_offset, 3'b000} +: BYTE_W] <= byte_wdata;
        end
    end

    assign line_valid = valid_vec[rd_index];
    assign line_dirty = dirty_vec[rd_index];
    assign line_tag   = tag_mem[rd_index];
    assign line_data  = data_mem[rd_index];
    assign rd_byte    = line_data[{rd_offset, 3'b000} +: BYTE_W];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: zero-stall hits, and
// misses that write back a dirty victim before refilling from main memory.
module data_cache
    import dcache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                READ,
    input  logic                WRITE,
    input  logic [7:0]          ADDRESS,
    input  logic [BYTE_W-1:0]   WRITEDATA,
    output logic [BYTE_W-1:0]   READDATA,
    output logic                BUSYWAIT,
    output logic                MEM_READ,
    output logic                MEM_WRITE,
    output logic [5:0]          MEM_ADDRESS,
    output logic [BLOCK_W-1:0]  MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]  MEM_READDATA,
    input  logic                MEM_BUSYWAIT
);
    state_t               state_reg;
    logic                 mem_read_reg;
    logic                 mem_write_reg;
    logic [5:0]           mem_address_reg;
    logic [BLOCK_W-1:0]   mem_writedata_reg;
    logic [5:0]           miss_block_reg;

    logic [TAG_W-1:0]     addr_tag;
    logic [INDEX_W-1:0]   addr_index;
    logic [OFFSET_W-1:0]  addr_offset;
    logic                 line_valid;
    logic                 line_dirty;
    logic [TAG_W-1:0]     line_tag;
    logic [BLOCK_W-1:0]   line_data;
    logic [BYTE_W-1:0]    rd_byte;
    logic                 hit;
    logic                 idle_hit;
    logic                 req;
    logic                 refill_we;

    assign addr_tag    = ADDRESS[7:5];
    assign addr_index  = ADDRESS[4:2];
    assign addr_offset = ADDRESS[1:0];

    assign hit       = line_valid && (line_tag == addr_tag);
    assign idle_hit  = (state_reg == IDLE) && hit;
    assign req       = READ || WRITE;
    assign refill_we = (state_reg == FETCH) && !MEM_BUSYWAIT;

    assign BUSYWAIT = req && !idle_hit && !RESET;
    assign READDATA = (READ && idle_hit) ? rd_byte : 8'h00;

    // Refill targets the block latched at miss detection, so a request dropped
    // mid-miss still installs the block that was actually fetched.
    dcache_line_array u_lines (
        .CLK          (CLK),
        .RESET        (RESET),
        .rd_index     (addr_index),
        .rd_offset    (addr_offset),
        .byte_we      (WRITE && idle_hit),
        .byte_wdata   (WRITEDATA),
        .refill_we    (refill_we),
        .refill_index (miss_block_reg[INDEX_W-1:0]),
        .refill_tag   (miss_block_reg[5:INDEX_W]),
        .refill_data  (MEM_READDATA),
        .line_valid   (line_valid),
        .line_dirty   (line_dirty),
        .line_tag     (line_tag),
        .line_data    (line_data),
        .rd_byte      (rd_byte)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg         <= IDLE;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            mem_address_reg   <= '0;
            mem_writedata_reg <= '0;
            miss_block_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req && !hit) begin
                        miss_block_reg <= ADDRESS[7:2];
                        if (line_valid && line_dirty) begin
                            state_reg         <= WRITEBACK;
                            mem_write_reg     <= 1'b1;
                            mem_address_reg   <= {line_tag, addr_index};
                            mem_writedata_reg <= line_data;
                        end else begin
                            state_reg       <= FETCH;
                            mem_read_reg    <= 1'b1;
                            mem_address_reg <= ADDRESS[7:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state_reg         <= FETCH;
                        mem_write_reg     <= 1'b0;
                        mem_writedata_reg <= '0;
                        mem_read_reg      <= 1'b1;
                        mem_address_reg   <= miss_block_reg;
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state_reg       <= IDLE;
                        mem_read_reg    <= 1'b0;
                        mem_address_reg <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign MEM_READ      = mem_read_reg;
    assign MEM_WRITE     = mem_write_reg;
    assign MEM_ADDRESS   = mem_address_reg;
    assign MEM_WRITEDATA = mem_writedata_reg;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a fixed-latency block memory model.
module tb_data_cache;
    localparam int MEM_LAT = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    logic [31:0] mem_array [64];
    int          mem_cnt = 0;

    int tests_run = 0;
    int tests_failed = 0;

    // Results of the most recent access
    int          acc_stalls;
    logic [7:0]  acc_rdata;
    logic        acc_saw_write;
    logic        acc_saw_read;
    logic        acc_saw_both;
    logic [5:0]  acc_wb_addr;
    logic [31:0] acc_wb_data;
    logic [5:0]  acc_rd_addr;

    always #5 CLK = ~CLK;

    data_cache u_dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    // Memory: busy for MEM_LAT cycles of a request, then one low completing cycle.
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt != MEM_LAT);
    assign MEM_READDATA = mem_array[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 64; i++) mem_array[i] <= {8'hE0, 8'(i), 8'hC3, 8'h5A};
            mem_array[6'h09] <= 32'h44332211;
            mem_array[6'h29] <= 32'hDDCCBBAA;
            mem_array[6'h00] <= 32'h13121110;
            mem_array[6'h11] <= 32'h77665544;
            mem_cnt <= 0;
        end else if (MEM_READ || MEM_WRITE) begin
            if (mem_cnt == MEM_LAT) begin
                mem_cnt <= 0;
                if (MEM_WRITE) mem_array[MEM_ADDRESS] <= MEM_WRITEDATA;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Drive one request at a negedge and hold it through the completing posedge.
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wdata);
        acc_stalls = 0;
        acc_saw_write = 1'b0;
        acc_saw_read = 1'b0;
        acc_saw_both = 1'b0;
        acc_wb_addr = '0;
        acc_wb_data = '0;
        acc_rd_addr = '0;
        @(negedge CLK);
        READ = rd;
        WRITE = wr;
        ADDRESS = addr;
        WRITEDATA = wdata;
        #1;
        while (BUSYWAIT && acc_stalls < 100) begin
            acc_stalls++;
            if (MEM_WRITE) begin
                acc_saw_write = 1'b1;
                acc_wb_addr = MEM_ADDRESS;
                acc_wb_data = MEM_WRITEDATA;
            end
            if (MEM_READ) begin
                acc_saw_read = 1'b1;
                acc_rd_addr = MEM_ADDRESS;
            end
            if (MEM_READ && MEM_WRITE) acc_saw_both = 1'b1;
            @(negedge CLK);
            #1;
        end
        if (acc_stalls >= 100) begin
            tests_run++;
            tests_failed++;
            $display("FAIL access_timeout addr=%02h: BUSYWAIT still high after %0d cycles", addr, acc_stalls);
        end
        acc_rdata = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0;
        WRITE = 1'b0;
        $display("[TB] %s addr=%02h wdata=%02h stalls=%0d rdata=%02h", wr ? "WRITE" : "READ ",
                 addr, wdata, acc_stalls, acc_rdata);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        READ = 1'b1;
        ADDRESS = 8'h24;
        #1;
        tests_run++;
        if (BUSYWAIT !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busywait: got %b want 0", BUSYWAIT);
        end
        tests_run++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, READDATA} !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wdata=%h rdata=%h want all 0",
                     MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, READDATA);
        end
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_clean_miss();
        do_access(1'b1, 1'b0, 8'h24, 8'h00);
        tests_run++;
        if (acc_stalls !== 6) begin
            tests_failed++;
            $display("FAIL clean_miss_stalls: got %0d want 6", acc_stalls);
        end
        tests_run++;
        if (acc_saw_write !== 1'b0 || acc_rd_addr !== 6'h09) begin
            tests_failed++;
            $display("FAIL clean_miss_mem: got write=%b fetch_addr=%h want write=0 fetch_addr=09",
                     acc_saw_write, acc_rd_addr);
        end
        tests_run++;
        if (acc_rdata !== 8'h11) begin
            tests_failed++;
            $display("FAIL clean_miss_data: got %h want 11", acc_rdata);
        end
    endtask

    task automatic test_hit();
        do_access(1'b1, 1'b0, 8'h27, 8'h00);
        tests_run++;
        if (acc_stalls !== 0 || acc_rdata !== 8'h44) begin
            tests_failed++;
            $display("FAIL read_hit: got stalls=%0d data=%h want stalls=0 data=44", acc_stalls, acc_rdata);
        end
    endtask

    task automatic test_write_hit();
        do_access(1'b0, 1'b1, 8'h25, 8'hAB);
        tests_run++;
        if (acc_stalls !== 0) begin
            tests_failed++;
            $display("FAIL write_hit_stalls: got %0d want 0", acc_stalls);
        end
        do_access(1'b1, 1'b0, 8'h25, 8'h00);
        tests_run++;
        if (acc_stalls !== 0 || acc_rdata !== 8'hAB) begin
            tests_failed++;
            $display("FAIL write_hit_readback: got stalls=%0d data=%h want stalls=0 data=AB",
                     acc_stalls, acc_rdata);
        end
        tests_run++;
        if (u_dut.u_lines.dirty_vec[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_hit_dirty: got %b want 1", u_dut.u_lines.dirty_vec[1]);
        end
    endtask

    task automatic test_dirty_miss();
        do_access(1'b1, 1'b0, 8'hA4, 8'h00);
        tests_run++;
        if (acc_saw_write !== 1'b1 || acc_wb_addr !== 6'h09 || acc_wb_data !== 32'h4433AB11) begin
            tests_failed++;
            $display("FAIL dirty_miss_writeback: got seen=%b addr=%h data=%h want 1 09 4433AB11",
                     acc_saw_write, acc_wb_addr, acc_wb_data);
        end
        tests_run++;
        if (acc_saw_read !== 1'b1 || acc_rd_addr !== 6'h29 || acc_saw_both !== 1'b0) begin
            tests_failed++;
            $display("FAIL dirty_miss_fetch: got seen=%b addr=%h both=%b want 1 29 0",
                     acc_saw_read, acc_rd_addr, acc_saw_both);
        end
        tests_run++;
        if (acc_stalls !== 11 || acc_rdata !== 8'hAA) begin
            tests_failed++;
            $display("FAIL dirty_miss_result: got stalls=%0d data=%h want stalls=11 data=AA",
                     acc_stalls, acc_rdata);
        end
        tests_run++;
        if (mem_array[6'h09] !== 32'h4433AB11) begin
            tests_failed++;
            $display("FAIL dirty_miss_memory: got %h want 4433AB11", mem_array[6'h09]);
        end
    endtask

    task automatic test_write_miss();
        do_access(1'b0, 1'b1, 8'h03, 8'h5A);
        tests_run++;
        if (acc_stalls !== 6 || acc_saw_write !== 1'b0 || acc_rd_addr !== 6'h00) begin
            tests_failed++;
            $display("FAIL write_miss_refill: got stalls=%0d write=%b fetch_addr=%h want 6 0 00",
                     acc_stalls, acc_saw_write, acc_rd_addr);
        end
        do_access(1'b1, 1'b0, 8'h03, 8'h00);
        tests_run++;
        if (acc_stalls !== 0 || acc_rdata !== 8'h5A) begin
            tests_failed++;
            $display("FAIL write_miss_byte: got stalls=%0d data=%h want 0 5A", acc_stalls, acc_rdata);
        end
        do_access(1'b1, 1'b0, 8'h00, 8'h00);
        tests_run++;
        if (acc_rdata !== 8'h10) begin
            tests_failed++;
            $display("FAIL write_miss_other_byte: got %h want 10", acc_rdata);
        end
        tests_run++;
        if (u_dut.u_lines.dirty_vec[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_miss_dirty: got %b want 1", u_dut.u_lines.dirty_vec[0]);
        end
    endtask

    task automatic test_reset_during_fetch();
        @(negedge CLK);
        READ = 1'b1;
        ADDRESS = 8'h44;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        tests_run++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h11) begin
            tests_failed++;
            $display("FAIL fetch_before_reset: got rd=%b addr=%h want 1 11", MEM_READ, MEM_ADDRESS);
        end
        RESET = 1'b1;
        #1;
        tests_run++;
        if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_fetch: got mem_read=%b busywait=%b want 0 0", MEM_READ, BUSYWAIT);
        end
        READ = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        $display("[TB] reset asserted during fetch, released");
        do_access(1'b1, 1'b0, 8'h44, 8'h00);
        tests_run++;
        if (acc_stalls !== 6 || acc_rd_addr !== 6'h11 || acc_rdata !== 8'h44) begin
            tests_failed++;
            $display("FAIL miss_after_reset: got stalls=%0d addr=%h data=%h want 6 11 44",
                     acc_stalls, acc_rd_addr, acc_rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 8'h46, 8'h00);
        tests_run++;
        if (acc_stalls !== 0 || acc_rdata !== 8'h66) begin
            tests_failed++;
            $display("FAIL back_to_back_hit: got stalls=%0d data=%h want 0 66", acc_stalls, acc_rdata);
        end
        do_access(1'b1, 1'b0, 8'h24, 8'h00);
        tests_run++;
        if (acc_stalls !== 6 || acc_rdata !== 8'h11) begin
            tests_failed++;
            $display("FAIL invalidated_by_reset: got stalls=%0d data=%h want 6 11", acc_stalls, acc_rdata);
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        test_reset();
        test_clean_miss();
        test_hit();
        test_write_hit();
        test_dirty_miss();
        test_write_miss();
        test_reset_during_fetch();
        test_back_to_back();
        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
